branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Fetch-side producer of the predicted next PC, paired with the ID-stage misprediction check.
//  Holds a direct-mapped BTB with 2-bit saturating counters and predicts pred_pc for the IF stage.
//  Consumes the ID-stage flush code: redirects fetch, flushes IF/ID, and trains the BTB.
// PARAMETERS
//  WORD_SIZE     16  data/address width
//  BTB_IDX_BITS  8   BTB index bits (2**8 = 256 entries); tag = pc[WORD_SIZE-1:BTB_IDX_BITS]
// PORTS
//  clk           in   1   rising-edge clock
//  reset_n       in   1   asynchronous active-low reset
//  stall         in   1   pipeline freeze; suppresses BTB updates
//  pc_IF         in   16  current fetch PC
//  pc_ID         in   16  PC of the instruction in ID
//  pc_1_ID       in   16  pc_ID+1 (fall-through)
//  flush_code    in   3   0 NICE_PRED,1 JMP_FLUSH,2 BR_FLUSH,3 NBR_FLUSH,4 JR_FLUSH
//  jmp_target    in   16  J-type target of ID instruction
//  br_target     in   16  branch target of ID instruction
//  jr_target     in   16  forwarded register target (JPR/JRL)
//  br_resolved   in   1   ID instruction is a conditional branch
//  br_taken      in   1   branch condition true
//  pred_pc       out  16  next fetch PC
//  flush_IF_ID   out  1   squash the instruction in IF/ID
// BEHAVIOUR
//  - Entry: valid, tag, target[15:0], is_jump, ctr[1:0]. Read index pc_IF[BTB_IDX_BITS-1:0].
//  - hit = valid && tag==pc_IF tag. Predicted taken = hit && (is_jump || ctr[1]).
//  - redirect = flush_code in {1,2,3,4}. Codes 5..7 are treated as NICE_PRED.
//  - redirect_pc: 1->jmp_target, 2->br_target, 3->pc_1_ID, 4->jr_target.
//  - pred_pc = redirect ? redirect_pc : taken ? target : pc_IF+1 (16-bit wrap, 0xFFFF+1=0x0000).
//  - flush_IF_ID = redirect. Both outputs are combinational, zero latency; redirect has priority.
//  - Training at posedge clk when !stall and reset_n high. Write index/tag come from pc_ID:
//      JMP_FLUSH: install {1,tag,jmp_target,is_jump=1,ctr=11}.
//      JR_FLUSH : install {1,tag,jr_target,is_jump=1,ctr=11}; last target wins.
//      BR_FLUSH : on hit, target=br_target and ctr+1 (sat 11); on miss, install with is_jump=0, ctr=10.
//      NBR_FLUSH: on hit, ctr-1 (sat 00), entry stays valid; on miss, no change.
//      NICE_PRED && br_resolved: on hit, ctr +1 if br_taken else -1, saturating; on miss, no change.
//  - Saturation: 11+1=11, 00-1=00. Counters never wrap.
//  - Same-cycle read of pc_IF index and write of pc_ID index: the read sees old contents (write-after-read).
//  - stall=1: no table write; redirect/pred_pc still evaluated. The held ID instruction trains once, on the unstalled cycle.
//  - Reset (async, any time): all valid=0 and ctr=01 immediately. pred_pc=pc_IF+1; flush_IF_ID follows flush_code.
// CONFIGURATION
//  BP_STATS_EN defined: adds outputs pred_cnt[15:0] and mispred_cnt[15:0].
//    - pred_cnt increments on each unstalled cycle with br_resolved or a J/JR instruction in ID.
//    - mispred_cnt increments on each unstalled cycle with redirect=1.
//    - Both wrap at 16 bits and reset to 0.
//  BP_STATS_EN undefined: counters and ports are absent; predictor behaviour is identical.
// STRUCTURE
//  - Shared header bp_defs: WORD_SIZE, FLUSH_CODE_SIZE, flush codes, CTR_WEAK_T=2'b10, CTR_STRONG_T=2'b11.
//    The ID-stage misprediction check includes the same header.
//  - One sub-module, btb_array: 1 async read port and 1 sync write port, with async clear of valid/ctr.
//    Redirect mux and training logic stay in branch_predictor.
// TESTING
//  1 reset_n=0 mid-run, pc_IF=0x0010 -> pred_pc=0x0011, flush_IF_ID=0, all entries invalid after release.
//  2 pc_ID=0x0020 JMP_FLUSH, jmp_target=0x0100 -> same cycle pred_pc=0x0100, flush=1;
//    later pc_IF=0x0020 -> pred_pc=0x0100.
//  3 pc_ID=0x0030 BR_FLUSH, br_target=0x0040 -> installs ctr=10; NBR_FLUSH on it -> ctr=01;
//    pc_IF=0x0030 -> pred_pc=0x0031.
//  4 four NICE_PRED taken resolves on a hit entry -> ctr=11 (saturated);
//    then three not-taken -> ctr=00, fourth not-taken -> ctr stays 00.
//  5 flush_code=4, jr_target=0x0200 with stall=1 -> pred_pc=0x0200, no BTB write;
//    stall=0 next cycle -> entry written once.
//  6 pc_IF=0xFFFF miss -> pred_pc=0x0000; flush_code=5 -> no redirect, no update.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared branch-prediction definitions: widths, flush codes, counter encodings and saturating helpers.
package bp_defs;

    localparam int WORD_SIZE       = 16;
    localparam int FLUSH_CODE_SIZE = 3;

    typedef enum logic [FLUSH_CODE_SIZE-1:0] {
        NICE_PRED = 3'd0,
        JMP_FLUSH = 3'd1,
        BR_FLUSH  = 3'd2,
        NBR_FLUSH = 3'd3,
        JR_FLUSH  = 3'd4
    } flush_code_e;

    localparam logic [1:0] CTR_WEAK_NT  = 2'b01;
    localparam logic [1:0] CTR_WEAK_T   = 2'b10;
    localparam logic [1:0] CTR_STRONG_T = 2'b11;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_btb_array.sv
// Direct-mapped BTB storage: async prediction read, async lookup at the write index, sync write.
// Latency: reads combinational, write visible the cycle after the clock edge (old data read same cycle).
// Backpressure: none; the caller gates wr_en.
module btb_array
    import bp_defs::*;
#(
    parameter int W   = 16,
    parameter int IDX = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [IDX-1:0] rd_idx,
    output logic           rd_valid,
    output logic [W-IDX-1:0] rd_tag,
    output logic [W-1:0]   rd_target,
    output logic           rd_is_jump,
    output logic [1:0]     rd_ctr,
    input  logic [IDX-1:0] wr_idx,
    output logic           lk_valid,
    output logic [W-IDX-1:0] lk_tag,
    output logic [W-1:0]   lk_target,
    output logic           lk_is_jump,
    output logic [1:0]     lk_ctr,
    input  logic           wr_en,
    input  logic [W-IDX-1:0] wr_tag,
    input  logic [W-1:0]   wr_target,
    input  logic           wr_is_jump,
    input  logic [1:0]     wr_ctr
);
    localparam int DEPTH = 2 ** IDX;

    logic             valid   [DEPTH];
    logic [1:0]       ctr     [DEPTH];
    logic [W-IDX-1:0] tag     [DEPTH];
    logic [W-1:0]     target  [DEPTH];
    logic             is_jump [DEPTH];

    assign rd_valid   = valid[rd_idx];
    assign rd_tag     = tag[rd_idx];
    assign rd_target  = target[rd_idx];
    assign rd_is_jump = is_jump[rd_idx];
    assign rd_ctr     = ctr[rd_idx];

    // Same-index lookup feeds the read-modify-write of the training path.
    assign lk_valid   = valid[wr_idx];
    assign lk_tag     = tag[wr_idx];
    assign lk_target  = target[wr_idx];
    assign lk_is_jump = is_jump[wr_idx];
    assign lk_ctr     = ctr[wr_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid[i] <= 1'b0;
                ctr[i]   <= CTR_WEAK_NT;
            end
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
            ctr[wr_idx]   <= wr_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag[wr_idx]     <= wr_tag;
            target[wr_idx]  <= wr_target;
            is_jump[wr_idx] <= wr_is_jump;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Next-PC predictor with BTB training from the ID-stage flush code; BP_STATS_EN adds prediction counters.
// Latency: pred_pc/flush_IF_ID combinational; BTB training lands on the next clock edge.
// Backpressure: stall freezes all state updates while outputs keep evaluating.
module branch_predictor #(
    parameter int WORD_SIZE    = bp_defs::WORD_SIZE,
    parameter int BTB_IDX_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic [WORD_SIZE-1:0] pc_IF,
    input  logic [WORD_SIZE-1:0] pc_ID,
    input  logic [WORD_SIZE-1:0] pc_1_ID,
    input  logic [bp_defs::FLUSH_CODE_SIZE-1:0] flush_code,
    input  logic [WORD_SIZE-1:0] jmp_target,
    input  logic [WORD_SIZE-1:0] br_target,
    input  logic [WORD_SIZE-1:0] jr_target,
    input  logic                 br_resolved,
    input  logic                 br_taken,
`ifdef BP_STATS_EN
    output logic [15:0]          pred_cnt,
    output logic [15:0]          mispred_cnt,
`endif
    output logic [WORD_SIZE-1:0] pred_pc,
    output logic                 flush_IF_ID
);
    import bp_defs::*;

    localparam int TAG_BITS = WORD_SIZE - BTB_IDX_BITS;

    flush_code_e code;
    assign code = flush_code_e'(flush_code);

    logic                 rd_valid, rd_is_jump, lk_valid, lk_is_jump;
    logic [TAG_BITS-1:0]  rd_tag, lk_tag;
    logic [WORD_SIZE-1:0] rd_target, lk_target;
    logic [1:0]           rd_ctr, lk_ctr;

    logic                 wr_req, wr_is_jump;
    logic [WORD_SIZE-1:0] wr_target;
    logic [1:0]           wr_ctr;

    btb_array #(.W(WORD_SIZE), .IDX(BTB_IDX_BITS)) u_btb (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_idx     (pc_IF[BTB_IDX_BITS-1:0]),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_target  (rd_target),
        .rd_is_jump (rd_is_jump),
        .rd_ctr     (rd_ctr),
        .wr_idx     (pc_ID[BTB_IDX_BITS-1:0]),
        .lk_valid   (lk_valid),
        .lk_tag     (lk_tag),
        .lk_target  (lk_target),
        .lk_is_jump (lk_is_jump),
        .lk_ctr     (lk_ctr),
        .wr_en      (wr_req && !stall),
        .wr_tag     (pc_ID[WORD_SIZE-1:BTB_IDX_BITS]),
        .wr_target  (wr_target),
        .wr_is_jump (wr_is_jump),
        .wr_ctr     (wr_ctr)
    );

    logic                 if_hit, if_taken, id_hit, redirect;
    logic [WORD_SIZE-1:0] redirect_pc;

    assign if_hit   = rd_valid && (rd_tag == pc_IF[WORD_SIZE-1:BTB_IDX_BITS]);
    assign if_taken = if_hit && (rd_is_jump || rd_ctr[1]);
    assign id_hit   = lk_valid && (lk_tag == pc_ID[WORD_SIZE-1:BTB_IDX_BITS]);

    always_comb begin
        redirect    = 1'b1;
        redirect_pc = pc_1_ID;
        case (code)
            JMP_FLUSH: redirect_pc = jmp_target;
            BR_FLUSH:  redirect_pc = br_target;
            NBR_FLUSH: redirect_pc = pc_1_ID;
            JR_FLUSH:  redirect_pc = jr_target;
            default:   redirect    = 1'b0;
        endcase
    end

    assign pred_pc     = redirect ? redirect_pc : (if_taken ? rd_target : pc_IF + 1'b1);
    assign flush_IF_ID = redirect;

    // Training: a write always rewrites the whole entry, so untouched fields are fed back from the lookup.
    always_comb begin
        wr_req     = 1'b0;
        wr_target  = lk_target;
        wr_is_jump = lk_is_jump;
        wr_ctr     = lk_ctr;
        case (code)
            JMP_FLUSH, JR_FLUSH: begin
                wr_req     = 1'b1;
                wr_target  = (code == JMP_FLUSH) ? jmp_target : jr_target;
                wr_is_jump = 1'b1;
                wr_ctr     = CTR_STRONG_T;
            end
            BR_FLUSH: begin
                wr_req    = 1'b1;
                wr_target = br_target;
                if (id_hit) begin
                    wr_ctr = ctr_inc(lk_ctr);
                end else begin
                    wr_is_jump = 1'b0;
                    wr_ctr     = CTR_WEAK_T;
                end
            end
            NBR_FLUSH: begin
                wr_req = id_hit;
                wr_ctr = ctr_dec(lk_ctr);
            end
            default: begin
                wr_req = br_resolved && id_hit;
                wr_ctr = br_taken ? ctr_inc(lk_ctr) : ctr_dec(lk_ctr);
            end
        endcase
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pred_cnt    <= 16'd0;
            mispred_cnt <= 16'd0;
        end else if (!stall) begin
            if (br_resolved || code == JMP_FLUSH || code == JR_FLUSH)
                pred_cnt <= pred_cnt + 16'd1;
            if (redirect)
                mispred_cnt <= mispred_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor: table of per-cycle stimulus plus a mid-run reset sequence.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [15:0] pc_IF, pc_ID, pc_1_ID;
    logic [2:0]  flush_code;
    logic [15:0] jmp_target, br_target, jr_target;
    logic        br_resolved, br_taken;
    logic [15:0] pred_pc;
    logic        flush_IF_ID;
`ifdef BP_STATS_EN
    logic [15:0] pred_cnt, mispred_cnt;
`endif

    branch_predictor #(.WORD_SIZE(16), .BTB_IDX_BITS(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (stall),
        .pc_IF       (pc_IF),
        .pc_ID       (pc_ID),
        .pc_1_ID     (pc_1_ID),
        .flush_code  (flush_code),
        .jmp_target  (jmp_target),
        .br_target   (br_target),
        .jr_target   (jr_target),
        .br_resolved (br_resolved),
        .br_taken    (br_taken),
`ifdef BP_STATS_EN
        .pred_cnt    (pred_cnt),
        .mispred_cnt (mispred_cnt),
`endif
        .pred_pc     (pred_pc),
        .flush_IF_ID (flush_IF_ID)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [15:0] pc_if;
        logic [15:0] pc_id;
        logic [2:0]  code;
        logic [15:0] jmp, br, jr;
        logic        res, tkn;
        logic [15:0] exp_pred;
        logic        exp_flush;
    } vec_t;

    localparam int NV = 45;
    vec_t tbl [NV];
    int   n_vec = 0;
    int   n_bad = 0;

    // Each target bus carries a distinct sentinel unless it is the one the code selects.
    function automatic vec_t mk(input logic st, input logic [15:0] pif, input logic [15:0] pid,
                                input logic [2:0] cd, input logic [15:0] tgt, input logic rs,
                                input logic tk, input logic [15:0] ep, input logic ef);
        vec_t v;
        v.stall = st; v.pc_if = pif; v.pc_id = pid; v.code = cd;
        v.jmp = (cd == 3'd1) ? tgt : 16'hDEAD;
        v.br  = (cd == 3'd2) ? tgt : 16'hBEEF;
        v.jr  = (cd == 3'd4) ? tgt : 16'hCAFE;
        v.res = rs; v.tkn = tk; v.exp_pred = ep; v.exp_flush = ef;
        return v;
    endfunction

    function automatic vec_t probe(input logic [15:0] pif, input logic [15:0] ep);
        return mk(1'b0, pif, 16'h0F00, 3'd0, 16'h0, 1'b0, 1'b0, ep, 1'b0);
    endfunction

    function automatic vec_t resolve(input logic [15:0] pid, input logic tk);
        return mk(1'b0, 16'h0000, pid, 3'd0, 16'h0, 1'b1, tk, 16'h0001, 1'b0);
    endfunction

    task automatic drive(input vec_t v);
        stall       = v.stall;
        pc_IF       = v.pc_if;
        pc_ID       = v.pc_id;
        pc_1_ID     = v.pc_id + 16'd1;
        flush_code  = v.code;
        jmp_target  = v.jmp;
        br_target   = v.br;
        jr_target   = v.jr;
        br_resolved = v.res;
        br_taken    = v.tkn;
    endtask

    task automatic check(input string name, input logic [15:0] ep, input logic ef);
        n_vec++;
        if (pred_pc !== ep || flush_IF_ID !== ef) begin
            n_bad++;
            $display("FAIL %s: pred_pc=%h flush_IF_ID=%b, required pred_pc=%h flush_IF_ID=%b",
                     name, pred_pc, flush_IF_ID, ep, ef);
        end
    endtask

    initial begin
        tbl[0]  = probe(16'h0010, 16'h0011);
        tbl[1]  = mk(0, 16'h0021, 16'h0020, 3'd1, 16'h0100, 0, 0, 16'h0100, 1);
        tbl[2]  = probe(16'h0020, 16'h0100);
        tbl[3]  = probe(16'h1020, 16'h1021);
        tbl[4]  = mk(0, 16'h0031, 16'h0030, 3'd2, 16'h0040, 0, 0, 16'h0040, 1);
        tbl[5]  = probe(16'h0030, 16'h0040);
        tbl[6]  = mk(0, 16'h0035, 16'h0030, 3'd3, 16'h0000, 0, 0, 16'h0031, 1);
        tbl[7]  = probe(16'h0030, 16'h0031);
        tbl[8]  = mk(0, 16'h0030, 16'h0030, 3'd0, 16'h0000, 1, 1, 16'h0031, 0);
        tbl[9]  = probe(16'h0030, 16'h0040);
        tbl[10] = mk(0, 16'h0033, 16'h0030, 3'd2, 16'h0044, 0, 0, 16'h0044, 1);
        tbl[11] = probe(16'h0030, 16'h0044);
        tbl[12] = mk(0, 16'h0051, 16'h0050, 3'd2, 16'h0060, 0, 0, 16'h0060, 1);
        tbl[13] = resolve(16'h0050, 1);
        tbl[14] = resolve(16'h0050, 1);
        tbl[15] = resolve(16'h0050, 1);
        tbl[16] = resolve(16'h0050, 1);
        tbl[17] = probe(16'h0050, 16'h0060);
        tbl[18] = resolve(16'h0050, 0);
        tbl[19] = probe(16'h0050, 16'h0060);
        tbl[20] = resolve(16'h0050, 0);
        tbl[21] = resolve(16'h0050, 0);
        tbl[22] = resolve(16'h0050, 0);
        tbl[23] = resolve(16'h0050, 1);
        tbl[24] = probe(16'h0050, 16'h0051);
        tbl[25] = resolve(16'h0050, 1);
        tbl[26] = probe(16'h0050, 16'h0060);
        tbl[27] = mk(0, 16'h0070, 16'h0070, 3'd0, 16'h0000, 1, 1, 16'h0071, 0);
        tbl[28] = probe(16'h0070, 16'h0071);
        tbl[29] = mk(0, 16'h0090, 16'h0080, 3'd3, 16'h0000, 0, 0, 16'h0081, 1);
        tbl[30] = probe(16'h0080, 16'h0081);
        tbl[31] = probe(16'hFFFF, 16'h0000);
        tbl[32] = mk(0, 16'h00A1, 16'h00A0, 3'd5, 16'h0123, 0, 0, 16'h00A2, 0);
        tbl[33] = probe(16'h00A0, 16'h00A1);
        tbl[34] = mk(0, 16'h00B0, 16'h00A0, 3'd7, 16'h0123, 0, 0, 16'h00B1, 0);
        tbl[35] = mk(1, 16'h00C1, 16'h00C0, 3'd1, 16'h0300, 0, 0, 16'h0300, 1);
        tbl[36] = probe(16'h00C0, 16'h00C1);
        tbl[37] = mk(1, 16'h0050, 16'h0050, 3'd0, 16'h0000, 1, 0, 16'h0060, 0);
        tbl[38] = probe(16'h0050, 16'h0060);
        tbl[39] = mk(1, 16'h00D1, 16'h00D0, 3'd4, 16'h0200, 0, 0, 16'h0200, 1);
        tbl[40] = probe(16'h00D0, 16'h00D1);
        tbl[41] = mk(0, 16'h00D1, 16'h00D0, 3'd4, 16'h0200, 0, 0, 16'h0200, 1);
        tbl[42] = probe(16'h00D0, 16'h0200);
        tbl[43] = mk(0, 16'h00D2, 16'h00D0, 3'd4, 16'h0210, 0, 0, 16'h0210, 1);
        tbl[44] = probe(16'h00D0, 16'h0210);

        reset_n = 1'b0;
        drive(probe(16'h0010, 16'h0011));
        #2;
        check("reset_idle", 16'h0011, 1'b0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            #4;
            check($sformatf("vec%0d", i), tbl[i].exp_pred, tbl[i].exp_flush);
            @(posedge clk);
            #1;
        end

        // Mid-cycle async reset must drop every entry immediately.
        drive(probe(16'h0020, 16'h0021));
        #2 reset_n = 1'b0;
        #1 check("rst_async_clear", 16'h0021, 1'b0);
        pc_IF = 16'h0010;
        #1 check("rst_pc_plus1", 16'h0011, 1'b0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        pc_IF = 16'h0030; #1 check("post_rst_0030", 16'h0031, 1'b0);
        pc_IF = 16'h0050; #1 check("post_rst_0050", 16'h0051, 1'b0);
        pc_IF = 16'h00D0; #1 check("post_rst_00D0", 16'h00D1, 1'b0);
        pc_IF = 16'h0020; #1 check("post_rst_0020", 16'h0021, 1'b0);
        @(posedge clk);
        #1;
        drive(mk(0, 16'h0021, 16'h0020, 3'd1, 16'h0100, 0, 0, 16'h0100, 1));
        #2 check("post_rst_jmp", 16'h0100, 1'b1);
        @(posedge clk);
        #1;
        drive(probe(16'h0020, 16'h0100));
        #2 check("post_rst_jmp_hit", 16'h0100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
